// File: rtl/sensor_filtro_pkg.sv
// Shared definitions for the sensor filter: sensor bit positions, FSM
// encoding and default timing parameters.
package sensor_filtro_pkg;

   localparam int unsigned TICK_DIV_DEF    = 50000;
   localparam int unsigned DEB_COUNT_DEF   = 8;
   localparam int unsigned ERR_PERSIST_DEF = 4;

   localparam int unsigned N_SENS = 6;
   localparam int unsigned IDX_H  = 0;
   localparam int unsigned IDX_M  = 1;
   localparam int unsigned IDX_L  = 2;
   localparam int unsigned IDX_US = 3;
   localparam int unsigned IDX_UA = 4;
   localparam int unsigned IDX_T  = 5;

   typedef enum logic [1:0] {
      ESPERA = 2'd0,
      ESTAB  = 2'd1,
      OPERA  = 2'd2
   } estado_t;

   // A higher level sensor reading wet while a lower one reads dry is impossible.
   function automatic logic nivel_incons(input logic h, input logic m, input logic l);
      return (h & ~m) | (m & ~l);
   endfunction

endpackage

// File: rtl/sensor_filtro_if.sv
// Sensor bundle: raw sensor inputs towards the filter, filtered levels and
// status flags back to the controller.
interface sensor_filtro_if;
   // No back-pressure: pronto qualifies the filtered outputs, which may be
   // sampled in any cycle; mudou is a single-cycle strobe.
   logic [5:0] sens_raw;
   logic       H;
   logic       M;
   logic       L;
   logic       Us;
   logic       Ua;
   logic       T;
   logic       pronto;
   logic       erro_nivel;
   logic       mudou;

   modport master (
      output sens_raw,
      input  H, M, L, Us, Ua, T, pronto, erro_nivel, mudou
   );

   modport slave (
      input  sens_raw,
      output H, M, L, Us, Ua, T, pronto, erro_nivel, mudou
   );
endinterface

// File: rtl/sensor_filtro_canal.sv
// One sensor channel: 2-flop synchronizer, tick-based debounce counter and
// filtered output register.
module filtro_canal #(
   parameter int unsigned DEB_COUNT = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   input  logic tick_i,
   input  logic load_i,
   output logic filt_o,
   output logic chg_o
);

   localparam int unsigned CW      = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_COUNT - 1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      chg_o  = 1'b0;
      if (tick_i) begin
         if (load_i) begin
            filt_d = sync2_q;
            cnt_d  = '0;
         end else if (sync2_q != filt_q) begin
            // Accept on the DEB_COUNT-th differing tick; counter never wraps.
            if (cnt_q == CNT_MAX) begin
               filt_d = sync2_q;
               cnt_d  = '0;
               chg_o  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/sensor_filtro.sv
// Sensor filter top: sample-tick prescaler, start-up FSM, six debounced
// channels and persistent water-level consistency check.
module sensor_filtro
   import sensor_filtro_pkg::*;
#(
   parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
   parameter int unsigned DEB_COUNT   = DEB_COUNT_DEF,
   parameter int unsigned ERR_PERSIST = ERR_PERSIST_DEF
) (
   input  logic              clock,
   input  logic              reset,
   sensor_filtro_if.slave    bus,
   output estado_t           estado_o
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned QW = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
   localparam int unsigned EW = (ERR_PERSIST > 1) ? $clog2(ERR_PERSIST) : 1;
   localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
   localparam logic [QW-1:0] QMAX     = QW'(DEB_COUNT - 1);
   localparam logic [EW-1:0] EMAX     = EW'(ERR_PERSIST - 1);

   logic [PW-1:0] presc_q, presc_d;
   estado_t       estado_q, estado_d;
   logic [QW-1:0] quiet_q, quiet_d;
   logic [EW-1:0] pcnt_q, pcnt_d;
   logic          erro_q, erro_d;
   logic          mudou_q, mudou_d;

   logic              tick;
   logic              carga;
   logic              incons;
   logic [N_SENS-1:0] filt;
   logic [N_SENS-1:0] chg;

   assign tick  = (presc_q == TICK_MAX);
   assign carga = (estado_q == ESPERA);

   for (genvar i = 0; i < N_SENS; i++) begin : gen_canal
      filtro_canal #(.DEB_COUNT(DEB_COUNT)) u_canal (
         .clock  (clock),
         .reset  (reset),
         .raw_i  (bus.sens_raw[i]),
         .tick_i (tick),
         .load_i (carga),
         .filt_o (filt[i]),
         .chg_o  (chg[i])
      );
   end

   always_comb begin
      presc_d = (presc_q == TICK_MAX) ? '0 : presc_q + 1'b1;
   end

   always_comb begin
      estado_d = estado_q;
      quiet_d  = quiet_q;
      case (estado_q)
         ESPERA: begin
            if (tick) begin
               estado_d = ESTAB;
               quiet_d  = '0;
            end
         end
         ESTAB: begin
            // Need DEB_COUNT consecutive ticks without any output change.
            if (tick) begin
               if (|chg) begin
                  quiet_d = '0;
               end else if (quiet_q == QMAX) begin
                  estado_d = OPERA;
                  quiet_d  = '0;
               end else begin
                  quiet_d = quiet_q + 1'b1;
               end
            end
         end
         OPERA: estado_d = OPERA;
         default: begin
            estado_d = ESPERA;
            quiet_d  = '0;
         end
      endcase
   end

   assign incons = nivel_incons(filt[IDX_H], filt[IDX_M], filt[IDX_L]);

   always_comb begin
      pcnt_d = pcnt_q;
      erro_d = erro_q;
      if (estado_q != OPERA) begin
         pcnt_d = '0;
         erro_d = 1'b0;
      end else if (tick) begin
         if (incons != erro_q) begin
            if (pcnt_q == EMAX) begin
               erro_d = incons;
               pcnt_d = '0;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end else begin
            pcnt_d = '0;
         end
      end
   end

   assign mudou_d = |chg;

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q  <= '0;
         estado_q <= ESPERA;
         quiet_q  <= '0;
         pcnt_q   <= '0;
         erro_q   <= 1'b0;
         mudou_q  <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         estado_q <= estado_d;
         quiet_q  <= quiet_d;
         pcnt_q   <= pcnt_d;
         erro_q   <= erro_d;
         mudou_q  <= mudou_d;
      end
   end

   assign bus.H          = filt[IDX_H];
   assign bus.M          = filt[IDX_M];
   assign bus.L          = filt[IDX_L];
   assign bus.Us         = filt[IDX_US];
   assign bus.Ua         = filt[IDX_UA];
   assign bus.T          = filt[IDX_T];
   assign bus.pronto     = (estado_q == OPERA);
   assign bus.erro_nivel = erro_q;
   assign bus.mudou      = mudou_q;
   assign estado_o       = estado_q;

endmodule

// File: tb/tb_sensor_filtro.sv
// Bench for sensor_filtro: directed scenarios plus randomized traffic checked
// against a tick-level behavioural model through an expected-value queue.
module tb_sensor_filtro;
   import sensor_filtro_pkg::*;

   localparam int TD = 4;
   localparam int DB = 3;
   localparam int EP = 2;

   logic    clock = 1'b0;
   logic    reset;
   estado_t estado;

   sensor_filtro_if bus ();

   sensor_filtro #(
      .TICK_DIV   (TD),
      .DEB_COUNT  (DB),
      .ERR_PERSIST(EP)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .estado_o (estado)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   logic seen_us, seen_mud;
   int   mud_cnt;

   // Reference model, advanced once per clock edge in terms of ticks.
   int         m_cyc = 0;
   int         m_ticks = 0;
   logic [5:0] m_s1 = '0, m_s2 = '0, m_out = '0;
   int         m_run[6];
   int         m_phase = 0;
   int         m_quiet = 0;
   logic       m_err = 1'b0;
   int         m_ecnt = 0;
   logic       m_mud = 1'b0;

   function automatic logic [8:0] obs_vec();
      return {bus.erro_nivel, bus.pronto, bus.mudou,
              bus.T, bus.Ua, bus.Us, bus.L, bus.M, bus.H};
   endfunction

   always @(posedge clock) begin : model
      logic [5:0] sv;
      logic       tk, chg, inc;
      int         ph;
      if (reset) begin
         m_cyc = 0; m_ticks = 0; m_s1 = '0; m_s2 = '0; m_out = '0;
         foreach (m_run[c]) m_run[c] = 0;
         m_phase = 0; m_quiet = 0; m_err = 1'b0; m_ecnt = 0; m_mud = 1'b0;
      end else begin
         tk  = ((m_cyc % TD) == TD - 1);
         m_cyc++;
         sv  = m_s2;
         chg = 1'b0;
         ph  = m_phase;
         inc = (m_out[0] & ~m_out[1]) | (m_out[1] & ~m_out[2]);
         if (tk) begin
            m_ticks++;
            if (ph == 0) begin
               m_out   = sv;
               m_phase = 1;
            end else begin
               for (int c = 0; c < 6; c++) begin
                  if (sv[c] != m_out[c]) begin
                     m_run[c]++;
                     if (m_run[c] == DB) begin
                        m_out[c] = sv[c];
                        m_run[c] = 0;
                        chg = 1'b1;
                     end
                  end else begin
                     m_run[c] = 0;
                  end
               end
               if (ph == 1) begin
                  if (chg) m_quiet = 0;
                  else begin
                     m_quiet++;
                     if (m_quiet == DB) begin
                        m_phase = 2;
                        m_quiet = 0;
                     end
                  end
               end else begin
                  if (inc != m_err) begin
                     m_ecnt++;
                     if (m_ecnt == EP) begin
                        m_err  = inc;
                        m_ecnt = 0;
                     end
                  end else m_ecnt = 0;
               end
            end
         end
         m_mud = chg;
         m_s2  = m_s1;
         m_s1  = bus.sens_raw;
      end
      exp_q.push_back({m_err, (m_phase == 2), m_mud, m_out});
   end

   always @(negedge clock) begin : scoreboard
      logic [8:0] e, o;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_vec();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got=%b expected=%b", $time, o, e);
         end
      end
   end

   task automatic wait_tick();
      int start;
      int n;
      start = m_ticks;
      n = 0;
      do begin
         @(negedge clock);
         n++;
         seen_us  |= bus.Us;
         seen_mud |= bus.mudou;
         mud_cnt  += int'(bus.mudou);
      end while (m_ticks == start && n < 4 * TD);
      if (m_ticks == start) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout got=no_tick expected=tick within %0d cycles", 4 * TD);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.sens_raw = 6'($urandom_range(0, 63));
      repeat (3) @(negedge clock);
      checks++;
      if (obs_vec() !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b expected=%b", obs_vec(), 9'b0);
      end
      checks++;
      if (estado !== ESPERA) begin
         errors++;
         $display("FAIL reset_state got=%0d expected=%0d", estado, ESPERA);
      end
   endtask

   task automatic test_startup();
      reset = 1'b1;
      bus.sens_raw = 6'b000111;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      mud_cnt = 0;
      wait_tick();
      checks++;
      if (obs_vec() !== 9'b000_000111) begin
         errors++;
         $display("FAIL startup_load got=%b expected=%b", obs_vec(), 9'b000_000111);
      end
      wait_tick();
      wait_tick();
      checks++;
      if (bus.pronto !== 1'b0 || estado !== ESTAB) begin
         errors++;
         $display("FAIL startup_not_ready got=pronto %b state %0d expected=pronto 0 state %0d",
                  bus.pronto, estado, ESTAB);
      end
      wait_tick();
      checks++;
      if (bus.pronto !== 1'b1 || estado !== OPERA) begin
         errors++;
         $display("FAIL startup_ready got=pronto %b state %0d expected=pronto 1 state %0d",
                  bus.pronto, estado, OPERA);
      end
      checks++;
      if (mud_cnt !== 0) begin
         errors++;
         $display("FAIL startup_no_mudou got=%0d pulses expected=0", mud_cnt);
      end
   endtask

   task automatic test_glitch();
      wait_tick();
      bus.sens_raw[IDX_US] = 1'b1;
      seen_us  = 1'b0;
      seen_mud = 1'b0;
      wait_tick();
      wait_tick();
      bus.sens_raw[IDX_US] = 1'b0;
      repeat (3) wait_tick();
      checks++;
      if (seen_us !== 1'b0) begin
         errors++;
         $display("FAIL glitch_us got=%b expected=0", seen_us);
      end
      checks++;
      if (seen_mud !== 1'b0) begin
         errors++;
         $display("FAIL glitch_mudou got=%b expected=0", seen_mud);
      end
   endtask

   task automatic test_accept();
      bus.sens_raw[IDX_US] = 1'b1;
      wait_tick();
      wait_tick();
      checks++;
      if (bus.Us !== 1'b0) begin
         errors++;
         $display("FAIL accept_early got=%b expected=0", bus.Us);
      end
      wait_tick();
      checks++;
      if (bus.Us !== 1'b1 || bus.mudou !== 1'b1) begin
         errors++;
         $display("FAIL accept_third got=Us %b mudou %b expected=Us 1 mudou 1", bus.Us, bus.mudou);
      end
      @(negedge clock);
      checks++;
      if (bus.Us !== 1'b1 || bus.mudou !== 1'b0) begin
         errors++;
         $display("FAIL accept_pulse_end got=Us %b mudou %b expected=Us 1 mudou 0", bus.Us, bus.mudou);
      end
   endtask

   task automatic test_erro();
      bus.sens_raw = 6'b001101;
      repeat (3) wait_tick();
      checks++;
      if (bus.M !== 1'b0 || bus.erro_nivel !== 1'b0) begin
         errors++;
         $display("FAIL erro_m_drop got=M %b erro %b expected=M 0 erro 0", bus.M, bus.erro_nivel);
      end
      wait_tick();
      checks++;
      if (bus.erro_nivel !== 1'b0) begin
         errors++;
         $display("FAIL erro_set_early got=%b expected=0", bus.erro_nivel);
      end
      wait_tick();
      checks++;
      if (bus.erro_nivel !== 1'b1) begin
         errors++;
         $display("FAIL erro_set got=%b expected=1", bus.erro_nivel);
      end
      bus.sens_raw = 6'b001111;
      repeat (3) wait_tick();
      checks++;
      if (bus.M !== 1'b1 || bus.erro_nivel !== 1'b1) begin
         errors++;
         $display("FAIL erro_m_back got=M %b erro %b expected=M 1 erro 1", bus.M, bus.erro_nivel);
      end
      wait_tick();
      checks++;
      if (bus.erro_nivel !== 1'b1) begin
         errors++;
         $display("FAIL erro_clear_early got=%b expected=1", bus.erro_nivel);
      end
      wait_tick();
      checks++;
      if (bus.erro_nivel !== 1'b0) begin
         errors++;
         $display("FAIL erro_clear got=%b expected=0", bus.erro_nivel);
      end
   endtask

   task automatic test_multi_change();
      bus.sens_raw = 6'b101100;
      mud_cnt = 0;
      repeat (3) wait_tick();
      checks++;
      if ({bus.T, bus.Ua, bus.Us, bus.L, bus.M, bus.H} !== 6'b101100 || bus.mudou !== 1'b1) begin
         errors++;
         $display("FAIL multi_change got=%b mudou %b expected=101100 mudou 1",
                  {bus.T, bus.Ua, bus.Us, bus.L, bus.M, bus.H}, bus.mudou);
      end
      repeat (2) wait_tick();
      checks++;
      if (mud_cnt !== 1) begin
         errors++;
         $display("FAIL multi_single_pulse got=%0d pulses expected=1", mud_cnt);
      end
   endtask

   task automatic test_random(input int n_iter);
      for (int it = 0; it < n_iter; it++) begin
         if ($urandom_range(0, 1) == 0)
            bus.sens_raw = 6'($urandom_range(0, 63));
         else
            bus.sens_raw[$urandom_range(0, 5)] = ~bus.sens_raw[$urandom_range(0, 5)];
         repeat ($urandom_range(1, 30)) @(negedge clock);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bus.sens_raw = ~bus.sens_raw;
      wait_tick();
      n = 0;
      while ((m_cyc % TD) != TD - 1 && n < 2 * TD) begin
         @(negedge clock);
         n++;
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (obs_vec() !== 9'b0 || estado !== ESPERA) begin
         errors++;
         $display("FAIL reset_mid got=%b state %0d expected=%b state %0d",
                  obs_vec(), estado, 9'b0, ESPERA);
      end
      reset = 1'b0;
      test_random(20);
   endtask

   initial begin
      reset = 1'b1;
      bus.sens_raw = '0;
      seen_us = 1'b0;
      seen_mud = 1'b0;
      mud_cnt = 0;
      test_reset();
      test_startup();
      test_glitch();
      test_accept();
      test_erro();
      test_multi_change();
      test_random(60);
      test_reset_mid();
      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=no finish expected=finish before %0t", $time);
      $fatal(1);
   end

endmodule
